pipe_csa_adder: RTL and testbench
=================================

# pipe_csa_adder

Parametrised, pipelined carry-select adder/subtractor with a valid/ready handshake on both sides. Operands are split into `BLK`-bit slices; each pipeline stage resolves one slice by carry-select (both carry-in hypotheses summed, registered carry picks one) and passes the carry to the next stage. It replaces the fixed 32-bit single-cycle carry-select adder in datapaths that need higher clock rates, arbitrary widths, subtraction and back-pressure.

## Interface

Parameters:
- `WIDTH`, 32: operand and sum width; must be a multiple of `BLK`.
- `BLK`, 8: slice width per stage, ≥ 2. `NSTG = WIDTH/BLK` stages, ≥ 1.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `R`  in  WIDTH  operand A.
- `T`  in  WIDTH  operand B.
- `Cin`  in  1  carry-in (add) / borrow-in (sub).
- `sub`  in  1  0: `R + T + Cin`; 1: `R - T - Cin`, computed as `R + ~T + !Cin`.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  block can accept.
- `sum`  out  WIDTH  result.
- `Cout`  out  1  raw carry out of MSB (for sub: 1 = no borrow).
- `OF`  out  1  signed overflow.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts.

## Operation

- Effective B = `sub ? ~T : T`; effective carry-in = `sub ? !Cin : Cin`.
- Stage k (0..NSTG-1) holds slice k: computes `s0 = A_k + B_k + 0`, `s1 = A_k + B_k + 1`, selects with carry from stage k-1 (stage 0: effective carry-in), registers the selected slice and its carry-out.
- Upper operand slices are skew-delayed; lower finished sum slices are de-skewed so `sum` leaves aligned.
- `OF` = carry into MSB XOR carry out of MSB, computed in the last stage.
- Each stage carries a valid bit; bubbles propagate as invalid stages.
- Global stall: `stall = out_valid && !out_ready`. While stalled, every stage register, including bubbles, holds. No bubble collapsing.
- `in_ready = !stall`. Transfer in occurs when `in_valid && in_ready` at a rising edge. Transfer out occurs when `out_valid && out_ready`.
- Results leave in acceptance order; none are dropped or duplicated.
- Wrap-around: sum is modulo 2^WIDTH unless saturation is compiled in.

## Timing

- Reset (asynchronous, immediate): all valid bits 0; all data and carry registers 0. Outputs: `sum=0`, `Cout=0`, `OF=0`, `out_valid=0`, `in_ready=1`.
- Reset mid-operation discards all in-flight results. After release, no stale result appears.
- Latency: NSTG rising edges, with the acceptance edge counted as edge 1. `out_valid` rises after edge NSTG. The default configuration has 4 cycles.
- Throughput: one result per cycle when `out_ready` stays high.
- Output held stable (`sum`, `Cout`, `OF`) while `out_valid && !out_ready`.
- Simultaneous input transfer and output transfer in the same cycle is legal and is the steady-state case.
- `in_ready` is combinational from `out_valid` and `out_ready` only. No combinational path from `in_valid` to `out_valid`.
- NSTG=1: a single registered stage with 1-cycle latency and the same handshake.

## Configuration

- `PIPE_CSA_SAT_EN` defined: on signed overflow, `sum` clamps. The result is `2^(WIDTH-1)-1` when the MSB of R is 0, and `2^(WIDTH-1)` when the MSB of R is 1. `OF` still reads 1, and `Cout` is unchanged (raw).
- Not defined: no clamp logic; `sum` wraps modulo 2^WIDTH.

## Test plan

- Reset: hold `rst=1` with random inputs. Required: `out_valid=0`, `sum=0`, `Cout=0`, `OF=0`, `in_ready=1`.
- Add carry ripple through all stages: `R=0xFFFFFFFF`, `T=0x00000001`, `Cin=0`, `sub=0`. Required: `sum=0x00000000`, `Cout=1`, `OF=0`, with `out_valid` exactly 4 edges after acceptance.
- Signed overflow: `R=0x7FFFFFFF`, `T=1`, `Cin=0`, `sub=0`. Required without the macro: `sum=0x80000000`, `OF=1`, `Cout=0`. Required with `PIPE_CSA_SAT_EN`: `sum=0x7FFFFFFF`, `OF=1`.
- Subtract with borrow: `R=5`, `T=7`, `Cin=0`, `sub=1`. Required: `sum=0xFFFFFFFE`, `Cout=0`, `OF=0`. Then `R=7`, `T=5`, `Cin=1`. Required: `sum=1`, `Cout=1`.
- Back-pressure: 8 back-to-back random transactions with `out_ready=0` for 3 cycles mid-stream. Required: `in_ready` drops exactly during the stall and results match the reference model in order, with none lost or duplicated.
- Reset mid-stream: assert `rst` with 3 transactions in flight. Required: `out_valid=0` immediately and no result emerges after release until new input.

Source files
------------

// File: rtl/pipe_csa_adder_if.sv
// pipe_csa_adder_if
//
// Purpose: bundles the operand/result valid-ready handshake of the pipelined
// carry-select adder into a single port.
//
// Signals:
//   R, T        operands A and B (WIDTH bits)
//   Cin         carry-in for add, borrow-in for subtract
//   sub         0 selects R + T + Cin, 1 selects R - T - Cin
//   in_valid    producer has operands ready
//   in_ready    adder can take operands this cycle
//   sum         result (WIDTH bits)
//   Cout        raw carry out of the MSB (for subtract: 1 means no borrow)
//   OF          signed overflow of the result
//   out_valid   result available
//   out_ready   consumer takes the result this cycle
//
// Modports:
//   master  the side that supplies operands and consumes results
//   slave   the adder itself
interface pipe_csa_adder_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] R;
  logic [WIDTH-1:0] T;
  logic             Cin;
  logic             sub;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum;
  logic             Cout;
  logic             OF;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output R, T, Cin, sub, in_valid, out_ready,
    input  in_ready, sum, Cout, OF, out_valid
  );

  modport slave (
    input  R, T, Cin, sub, in_valid, out_ready,
    output in_ready, sum, Cout, OF, out_valid
  );
endinterface

// File: rtl/pipe_csa_adder.sv
// pipe_csa_adder
//
// Purpose: pipelined carry-select adder/subtractor. The operands are cut into
// BLK-bit slices and stage k resolves slice k: both carry-in hypotheses are
// summed and the carry registered by stage k-1 picks one. Every stage carries
// the full operands forward, which gives the skew for the upper slices. It also
// carries the already-finished lower sum slices, which gives the de-skew, so
// the result leaves the last stage aligned. Latency is NSTG = WIDTH/BLK cycles,
// and throughput is one result per cycle.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset, clears every valid, data and carry
//   bus   pipe_csa_adder_if.slave: R, T, Cin, sub, in_valid, out_ready in;
//         in_ready, sum, Cout, OF, out_valid out
//
// Parameters:
//   WIDTH  operand/result width, a multiple of BLK
//   BLK    slice width per stage, at least 2
//
// Configuration macro:
//   PIPE_CSA_SAT_EN  when defined, a signed overflow clamps sum to the largest
//                    positive value (R non-negative) or the most negative value
//                    (R negative). OF and Cout are still reported raw.
module pipe_csa_adder #(
  parameter int WIDTH = 32,
  parameter int BLK   = 8
) (
  input logic             clk,
  input logic             rst,
  pipe_csa_adder_if.slave bus
);
  localparam int NSTG = WIDTH / BLK;

  logic [WIDTH-1:0] a_q [NSTG];
  logic [WIDTH-1:0] a_d [NSTG];
  logic [WIDTH-1:0] b_q [NSTG];
  logic [WIDTH-1:0] b_d [NSTG];
  logic [WIDTH-1:0] s_q [NSTG];
  logic [WIDTH-1:0] s_d [NSTG];
  logic [NSTG-1:0]  c_q;
  logic [NSTG-1:0]  c_d;
  logic [NSTG-1:0]  v_q;
  logic [NSTG-1:0]  v_d;
  logic             of_q;
  logic             of_d;

  logic [WIDTH-1:0] in_a [NSTG];
  logic [WIDTH-1:0] in_b [NSTG];
  logic [WIDTH-1:0] in_s [NSTG];
  logic [NSTG-1:0]  in_c;
  logic [NSTG-1:0]  in_v;

  logic             stall;
  logic [WIDTH-1:0] eff_b;
  logic             eff_cin;
  logic [BLK:0]     slice;
  logic             msb_carry_in;
  logic [WIDTH-1:0] final_sum;

  // Carry-select slice: both hypotheses are summed in parallel, and the
  // incoming carry chooses one. The top bit of the result is the slice carry-out.
  function automatic logic [BLK:0] slice_sel(input logic [BLK-1:0] a,
                                             input logic [BLK-1:0] b,
                                             input logic           cin);
    logic [BLK:0] s0;
    logic [BLK:0] s1;
    s0 = {1'b0, a} + {1'b0, b};
    s1 = {1'b0, a} + {1'b0, b} + {{BLK{1'b0}}, 1'b1};
    return cin ? s1 : s0;
  endfunction

  // The pipeline moves only as a whole. While the last stage holds a result
  // that the consumer refuses, every stage freezes, including bubbles.
  // Subtraction becomes addition of the inverted operand with the inverted
  // borrow.
  assign stall   = v_q[NSTG-1] && !bus.out_ready;
  assign eff_b   = bus.sub ? ~bus.T : bus.T;
  assign eff_cin = bus.sub ? !bus.Cin : bus.Cin;

  // Gather what each stage consumes. Stage 0 takes the operands straight from
  // the port, with an empty partial sum. Each later stage takes the registers
  // of the stage before it.
  always_comb begin
    in_a    = '{default: '0};
    in_b    = '{default: '0};
    in_s    = '{default: '0};
    in_c    = '0;
    in_v    = '0;
    in_a[0] = bus.R;
    in_b[0] = eff_b;
    in_s[0] = '0;
    in_c[0] = eff_cin;
    in_v[0] = bus.in_valid;
    for (int k = 1; k < NSTG; k++) begin
      in_a[k] = a_q[k-1];
      in_b[k] = b_q[k-1];
      in_s[k] = s_q[k-1];
      in_c[k] = c_q[k-1];
      in_v[k] = v_q[k-1];
    end
  end

  // Next-state computation for every stage. When stalled, everything holds.
  // Otherwise stage k writes its resolved slice into the partial sum and
  // passes on its carry. The last stage also derives the signed overflow from
  // the carries into and out of the MSB. The carry into the MSB is recovered
  // as a^b^sum at that bit.
  always_comb begin
    a_d          = a_q;
    b_d          = b_q;
    s_d          = s_q;
    c_d          = c_q;
    v_d          = v_q;
    of_d         = of_q;
    slice        = '0;
    msb_carry_in = 1'b0;
    final_sum    = '0;
    if (!stall) begin
      for (int k = 0; k < NSTG; k++) begin
        slice                  = slice_sel(in_a[k][k*BLK +: BLK],
                                           in_b[k][k*BLK +: BLK],
                                           in_c[k]);
        a_d[k]                 = in_a[k];
        b_d[k]                 = in_b[k];
        s_d[k]                 = in_s[k];
        s_d[k][k*BLK +: BLK]   = slice[BLK-1:0];
        c_d[k]                 = slice[BLK];
        v_d[k]                 = in_v[k];
      end
      msb_carry_in = in_a[NSTG-1][WIDTH-1] ^ in_b[NSTG-1][WIDTH-1]
                     ^ s_d[NSTG-1][WIDTH-1];
      of_d         = msb_carry_in ^ c_d[NSTG-1];
`ifdef PIPE_CSA_SAT_EN
      if (of_d) begin
        final_sum = in_a[NSTG-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                          : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
        final_sum = s_d[NSTG-1];
      end
`else
      final_sum = s_d[NSTG-1];
`endif
      s_d[NSTG-1] = final_sum;
    end
  end

  // Stage registers. An asynchronous reset empties the pipe and clears every
  // data and carry register, so no in-flight result survives it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NSTG; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      c_q  <= '0;
      v_q  <= '0;
      of_q <= 1'b0;
    end else begin
      for (int k = 0; k < NSTG; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
      c_q  <= c_d;
      v_q  <= v_d;
      of_q <= of_d;
    end
  end

  // The result is read directly from the last stage. The input side is ready
  // whenever the pipe is not frozen.
  assign bus.in_ready  = !stall;
  assign bus.out_valid = v_q[NSTG-1];
  assign bus.sum       = s_q[NSTG-1];
  assign bus.Cout      = c_q[NSTG-1];
  assign bus.OF        = of_q;
endmodule

// File: tb/tb_pipe_csa_adder.sv
// tb_pipe_csa_adder
//
// Purpose: self-checking bench for pipe_csa_adder in its default 32-bit,
// 4-stage configuration. The expected results come from an arithmetic model:
// the full add or subtract is done in 64-bit integers, and the signed range
// is checked directly.
module tb_pipe_csa_adder;
  localparam int WIDTH = 32;
  localparam int BLK   = 8;
  localparam int NSTG  = WIDTH / BLK;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pipe_csa_adder_if #(.WIDTH(WIDTH)) bus ();

  pipe_csa_adder #(.WIDTH(WIDTH), .BLK(BLK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             of;
  } expT;

  expT expQueue[$];
  int  checkCount = 0;
  int  errorCount = 0;

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference result from plain integer arithmetic. Subtraction is R - T - Cin;
  // Cout there means no borrow, that is, R >= T + Cin.
  function automatic expT refModel(input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] t,
                                   input logic cin, input logic sub);
    expT    e;
    longint ua, ub, sa, sb, ci, exact, sres;
    ua = longint'(r);
    ub = longint'(t);
    sa = longint'($signed(r));
    sb = longint'($signed(t));
    ci = cin ? 64'sd1 : 64'sd0;
    if (!sub) begin
      exact  = ua + ub + ci;
      e.cout = exact[WIDTH];
      sres   = sa + sb + ci;
    end else begin
      exact  = ua - ub - ci;
      e.cout = (ua >= ub + ci);
      sres   = sa - sb - ci;
    end
    e.sum = exact[WIDTH-1:0];
    e.of  = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
`ifdef PIPE_CSA_SAT_EN
    if (e.of) e.sum = r[WIDTH-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return e;
  endfunction

  // Operands biased toward the carry and overflow corners.
  function automatic logic [WIDTH-1:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard. At each falling edge, look at what the next rising edge will
  // transfer. A result leaving is compared against the oldest expectation; an
  // accepted operand set queues its model result.
  always @(negedge clk) begin
    expT e;
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        if (expQueue.size() == 0) begin
          checkOutput("unexpected_result", 64'(bus.out_valid), 64'h0);
        end else begin
          e = expQueue.pop_front();
          checkOutput("sb_sum", 64'(bus.sum), 64'(e.sum));
          checkOutput("sb_cout", 64'(bus.Cout), 64'(e.cout));
          checkOutput("sb_of", 64'(bus.OF), 64'(e.of));
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        expQueue.push_back(refModel(bus.R, bus.T, bus.Cin, bus.sub));
      end
    end
  end

  // Present one operand set and hold it until it is accepted. The task returns
  // just after the accepting edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] t,
                               input logic cin, input logic sub);
    int waitCycles;
    waitCycles   = 0;
    bus.R        = r;
    bus.T        = t;
    bus.Cin      = cin;
    bus.sub      = sub;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!bus.in_ready) checkOutput("accept_timeout", 64'(bus.in_ready), 64'h1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // One transaction into an empty pipe. Checks the latency in edges, counting
  // the acceptance edge as 1, and checks the exact result values.
  task automatic runDirected(input string tag, input logic [WIDTH-1:0] r,
                             input logic [WIDTH-1:0] t, input logic cin, input logic sub,
                             input logic [WIDTH-1:0] expSum, input logic expCout,
                             input logic expOf);
    int lat;
    bus.out_ready = 1'b1;
    applyStimulus(r, t, cin, sub);
    lat = 1;
    @(negedge clk);
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    checkOutput({tag, "_valid"}, 64'(bus.out_valid), 64'h1);
    checkOutput({tag, "_latency"}, 64'(lat), 64'(NSTG));
    checkOutput({tag, "_sum"}, 64'(bus.sum), 64'(expSum));
    checkOutput({tag, "_cout"}, 64'(bus.Cout), 64'(expCout));
    checkOutput({tag, "_of"}, 64'(bus.OF), 64'(expOf));
    @(posedge clk);
    #1;
  endtask

  // Let every outstanding result leave, then confirm nothing was lost.
  task automatic drainPipe(input string tag);
    int waitCycles;
    waitCycles    = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (expQueue.size() != 0 && waitCycles < 30) begin
      @(posedge clk);
      waitCycles++;
    end
    repeat (2) @(posedge clk);
    #1;
    checkOutput({tag, "_left"}, 64'(expQueue.size()), 64'h0);
    checkOutput({tag, "_idle"}, 64'(bus.out_valid), 64'h0);
  endtask

  initial begin
    int sent, stallDone, guard;
    bit acc;

    bus.R         = $urandom;
    bus.T         = $urandom;
    bus.Cin       = 1'($urandom_range(0, 1));
    bus.sub       = 1'($urandom_range(0, 1));
    bus.in_valid  = 1'($urandom_range(0, 1));
    bus.out_ready = 1'($urandom_range(0, 1));

    // Reset held with random activity on the inputs.
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_out_valid", 64'(bus.out_valid), 64'h0);
      checkOutput("rst_sum", 64'(bus.sum), 64'h0);
      checkOutput("rst_cout", 64'(bus.Cout), 64'h0);
      checkOutput("rst_of", 64'(bus.OF), 64'h0);
      checkOutput("rst_in_ready", 64'(bus.in_ready), 64'h1);
      bus.R         = $urandom;
      bus.T         = $urandom;
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    rst           = 1'b0;

    // Directed corners.
    runDirected("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
                32'h0000_0000, 1'b1, 1'b0);
`ifdef PIPE_CSA_SAT_EN
    runDirected("overflow", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
                32'h7FFF_FFFF, 1'b0, 1'b1);
`else
    runDirected("overflow", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
                32'h8000_0000, 1'b0, 1'b1);
`endif
    runDirected("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1,
                32'hFFFF_FFFE, 1'b0, 1'b0);
    runDirected("sub_noborrow", 32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1,
                32'h0000_0001, 1'b1, 1'b0);

    // Back-pressure. Eight back-to-back operand sets are sent. Once five have
    // been accepted the pipe is full, and the consumer refuses for three
    // cycles, so in_ready must be low exactly then.
    sent      = 0;
    stallDone = 0;
    guard     = 0;
    acc       = 1'b1;
    while (sent < 8 && guard < 40) begin
      if (acc) begin
        bus.R   = pickOperand();
        bus.T   = pickOperand();
        bus.Cin = 1'($urandom_range(0, 1));
        bus.sub = 1'($urandom_range(0, 1));
      end
      bus.in_valid  = 1'b1;
      bus.out_ready = !(sent == 5 && stallDone < 3);
      @(negedge clk);
      if (!bus.out_ready) begin
        checkOutput("bp_in_ready_stall", 64'(bus.in_ready), 64'h0);
        stallDone++;
      end else begin
        checkOutput("bp_in_ready_flow", 64'(bus.in_ready), 64'h1);
      end
      acc = bus.in_valid && bus.in_ready;
      if (acc) sent++;
      @(posedge clk);
      #1;
      guard++;
    end
    bus.in_valid = 1'b0;
    checkOutput("bp_stall_cycles", 64'(stallDone), 64'd3);
    checkOutput("bp_sent", 64'(sent), 64'd8);
    drainPipe("bp_drain");

    // Reset with results in flight. After the fourth acceptance the first
    // result is showing and three more are behind it.
    bus.out_ready = 1'b1;
    repeat (4) applyStimulus(pickOperand(), pickOperand(),
                             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    checkOutput("pre_rst_out_valid", 64'(bus.out_valid), 64'h1);
    rst = 1'b1;
    expQueue.delete();
    #1;
    checkOutput("mid_rst_out_valid", 64'(bus.out_valid), 64'h0);
    checkOutput("mid_rst_sum", 64'(bus.sum), 64'h0);
    checkOutput("mid_rst_in_ready", 64'(bus.in_ready), 64'h1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      checkOutput("post_rst_idle", 64'(bus.out_valid), 64'h0);
    end
    @(posedge clk);
    #1;
    runDirected("post_rst", 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0,
                32'h2222_2222, 1'b0, 1'b0);

    // Random traffic with random gaps on both sides.
    acc = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (!bus.in_valid || acc) begin
        bus.R        = pickOperand();
        bus.T        = pickOperand();
        bus.Cin      = 1'($urandom_range(0, 1));
        bus.sub      = 1'($urandom_range(0, 1));
        bus.in_valid = ($urandom_range(0, 3) != 0);
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
    end
    drainPipe("rand_drain");

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not reach the end, observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
